reg_file: RTL and testbench



---
 rtl/reg_file_pkg.sv | 15 +
 rtl/reg_file.sv | 59 +++++
 tb/tb_reg_file.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
// Shared core constants for the integer register file and its neighbours in
// the decode stage.
//   XLEN       : architectural integer width (default register/data width)
//   REG_ADDR_W : register select width (default 5 -> 32 registers)
//   ZERO_REG   : index of the hardwired-zero register (x0)
// -----------------------------------------------------------------------------
package reg_file_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ZERO_REG   = 0;

endpackage : reg_file_pkg

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
// General-purpose integer register file: 2^ADDR_WIDTH registers of DATA_WIDTH
// bits, two combinational read ports, one synchronous write port. Register 0
// is hardwired to zero. There is no write-to-read forwarding: a read of the
// register being written returns the old value until the clock edge (decode
// performs its own bypass).
//
// Ports:
//   clock      : single clock, all state updates on its rising edge
//   reset      : synchronous, active-high; clears every register, wins over wEn
//   read_sel1  : read port 1 register index (rs1)
//   read_sel2  : read port 2 register index (rs2)
//   wEn        : write enable
//   write_sel  : write register index (rd)
//   write_data : value to write
//   read_data1 : contents of register read_sel1 (combinational)
//   read_data2 : contents of register read_sel2 (combinational)
// -----------------------------------------------------------------------------
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_WIDTH = REG_ADDR_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] read_sel1,
    input  logic [ADDR_WIDTH-1:0] read_sel2,
    input  logic                  wEn,
    input  logic [ADDR_WIDTH-1:0] write_sel,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    localparam int                  NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_SEL = ADDR_WIDTH'(ZERO_REG);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wEn && (write_sel != ZERO_SEL)) begin
            regs[write_sel] <= write_data;
        end
    end

    // x0 is forced to zero on the read side so it reads 0 even before the
    // first reset, when the array contents are still undefined.
    always_comb begin
        read_data1 = (read_sel1 == ZERO_SEL) ? '0 : regs[read_sel1];
        read_data2 = (read_sel2 == ZERO_SEL) ? '0 : regs[read_sel2];
    end

endmodule : reg_file

// File: tb/tb_reg_file.sv
// -----------------------------------------------------------------------------
// tb_reg_file
// Self-checking bench for reg_file. Expected read values are pushed to a
// scoreboard queue when the selects are driven and popped/compared once the
// combinational read ports have settled.
// -----------------------------------------------------------------------------
module tb_reg_file;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clock;
    logic          reset;
    logic [AW-1:0] read_sel1;
    logic [AW-1:0] read_sel2;
    logic          wEn;
    logic [AW-1:0] write_sel;
    logic [DW-1:0] write_data;
    logic [DW-1:0] read_data1;
    logic [DW-1:0] read_data2;

    reg_file #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .read_sel1  (read_sel1),
        .read_sel2  (read_sel2),
        .wEn        (wEn),
        .write_sel  (write_sel),
        .write_data (write_data),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string         tag;
        int            port;
        logic [DW-1:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int        checks = 0;
    int        errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs,
                         input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive both selects, queue the expected outputs, let the combinational
    // read settle, then drain the scoreboard against the ports.
    task automatic expect_reads(input string tag, input logic [AW-1:0] s1,
                                input logic [AW-1:0] s2,
                                input logic [DW-1:0] e1,
                                input logic [DW-1:0] e2);
        sb_entry_t e;
        read_sel1 = s1;
        read_sel2 = s2;
        e.tag = {tag, "_p1"}; e.port = 1; e.exp = e1; sb_q.push_back(e);
        e.tag = {tag, "_p2"}; e.port = 2; e.exp = e2; sb_q.push_back(e);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, (e.port == 1) ? read_data1 : read_data2, e.exp);
        end
    endtask

    // Advance one rising edge and step off it before touching inputs again.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_reg(input logic [AW-1:0] sel, input logic [DW-1:0] data);
        wEn        = 1'b1;
        write_sel  = sel;
        write_data = data;
        tick();
        wEn        = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        wEn        = 1'b0;
        write_sel  = '0;
        write_data = '0;
        read_sel1  = '0;
        read_sel2  = '0;

        // x0 reads zero before any reset edge
        expect_reads("x0_prereset", 5'd0, 5'd0, 32'h0, 32'h0);

        tick();
        reset = 1'b0;

        // every index reads zero after reset, on both ports
        for (int i = 0; i < 32; i++) begin
            expect_reads($sformatf("rst_idx%0d", i), AW'(i), AW'(31 - i),
                         32'h0, 32'h0);
        end

        // write x5: old value before the edge, new value after
        wEn        = 1'b1;
        write_sel  = 5'd5;
        write_data = 32'hDEADBEEF;
        expect_reads("x5_before_edge", 5'd5, 5'd5, 32'h0, 32'h0);
        tick();
        wEn = 1'b0;
        expect_reads("x5_after_edge", 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF);

        // writes to x0 are discarded
        write_reg(5'd0, 32'h12345678);
        expect_reads("x0_write_ignored", 5'd0, 5'd5, 32'h0, 32'hDEADBEEF);

        // x1 / x31, then swap selects in the same cycle
        write_reg(5'd1, 32'h11111111);
        write_reg(5'd31, 32'hFFFFFFFF);
        expect_reads("x1_x31", 5'd1, 5'd31, 32'h11111111, 32'hFFFFFFFF);
        expect_reads("x31_x1_swap", 5'd31, 5'd1, 32'hFFFFFFFF, 32'h11111111);

        // both ports on the register being written: old value until the edge
        wEn        = 1'b1;
        write_sel  = 5'd1;
        write_data = 32'h0BADF00D;
        expect_reads("x1_same_before", 5'd1, 5'd1, 32'h11111111, 32'h11111111);
        tick();
        wEn = 1'b0;
        expect_reads("x1_same_after", 5'd1, 5'd1, 32'h0BADF00D, 32'h0BADF00D);
        expect_reads("x31_untouched", 5'd31, 5'd5, 32'hFFFFFFFF, 32'hDEADBEEF);

        // wEn low: no write
        wEn        = 1'b0;
        write_sel  = 5'd7;
        write_data = 32'hAAAA5555;
        tick();
        expect_reads("x7_no_wen", 5'd7, 5'd7, 32'h0, 32'h0);

        // store x9, then reset together with a write to x9
        write_reg(5'd9, 32'h00000042);
        expect_reads("x9_stored", 5'd9, 5'd5, 32'h00000042, 32'hDEADBEEF);
        reset      = 1'b1;
        wEn        = 1'b1;
        write_sel  = 5'd9;
        write_data = 32'h00000099;
        tick();
        reset = 1'b0;
        wEn   = 1'b0;
        expect_reads("x9_after_reset", 5'd9, 5'd9, 32'h0, 32'h0);
        for (int i = 0; i < 32; i++) begin
            expect_reads($sformatf("rst2_idx%0d", i), AW'(i), AW'(31 - i),
                         32'h0, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_reg_file
